wb_slave_router: RTL and testbench
==================================

Name: wb_slave_router

Overview:
- Registered Wishbone slave router inside user_project_wrapper. Sits between the management Wishbone port and two downstream slaves: the user project region and the debug register pair.
- Decodes each transaction once, at cycle start, and holds the selected target until the transaction ends.
- Forwards strobes to the selected target only and returns its ack and data through a registered response stage.
- A watchdog terminates any transaction the slave never acknowledges, and records it for software.

Parameters:
- DEBUG_BASE, 29'h601FFFF: value of wbs_adr_i[31:3] that selects the debug slave. Any other address selects the user slave.
- TIMEOUT_CYCLES, 255: number of BUSY cycles without a slave ack before the router forces termination. Legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the watchdog counter and of the timeout event counter.
- TIMEOUT_DATA, 32'hDEADBEEF: read data returned on a timed-out transaction.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous reset, active-high
- wbs_cyc_i  in  1  master cycle
- wbs_stb_i  in  1  master strobe
- wbs_we_i  in  1  master write enable
- wbs_sel_i  in  4  master byte select
- wbs_adr_i  in  32  master address
- wbs_dat_i  in  32  master write data
- wbs_ack_o  out  1  acknowledge to master
- wbs_dat_o  out  32  read data to master
- user_cyc_o  out  1  cycle to user slave
- user_stb_o  out  1  strobe to user slave
- user_ack_i  in  1  user slave ack
- user_dat_i  in  32  user slave read data
- debug_cyc_o  out  1  cycle to debug slave
- debug_stb_o  out  1  strobe to debug slave
- debug_ack_i  in  1  debug slave ack
- debug_dat_i  in  32  debug slave read data
- timeout_irq_o  out  1  sticky timeout flag
- timeout_cnt_o  out  CNT_W  saturating count of timeouts
- timeout_adr_o  out  32  address of the most recent timed-out transaction

Behaviour:
- Clock and reset: single clock wb_clk_i. wb_rst_i is synchronous, active-high, and dominates every other input.
- Reset values: all outputs 0, FSM in IDLE, watchdog 0, target register = user.
- Shared signals: we, sel, adr and dat are passed combinationally to both slaves. Only cyc and stb are gated per target.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - On wbs_cyc_i & wbs_stb_i: register target (debug if wbs_adr_i[31:3]==DEBUG_BASE, else user), clear watchdog, go to BUSY.
  - No slave cyc/stb is driven in IDLE.
- BUSY:
  - Selected target's cyc_o/stb_o = 1; the other target's = 0. Watchdog increments each cycle.
  - Target ack_i=1: register that target's dat_i into wbs_dat_o, go to RESP.
  - Watchdog == TIMEOUT_CYCLES-1 with no ack: wbs_dat_o = TIMEOUT_DATA, timeout_irq_o set, timeout_cnt_o incremented (saturates at all-ones), timeout_adr_o = wbs_adr_i, go to RESP.
  - Ack and timeout in the same cycle: the ack wins and no timeout is recorded.
  - wbs_cyc_i falls (master abort): drop slave strobes, go to IDLE, no ack, no timeout recorded.
  - An ack from the non-selected slave is ignored.
- RESP:
  - wbs_ack_o = 1 for exactly one cycle, slave strobes 0, then go to IDLE.
  - wbs_dat_o holds its value until the next response.
- Latency:
  - Request in IDLE at cycle N: slave stb at N+1.
  - Slave ack at cycle M: wbs_ack_o at M+1.
  - Minimum 3 cycles from request to ack. At least one IDLE cycle separates back-to-back transactions.
- Writes follow the same path. wbs_dat_o is don't-care for writes but is still registered.
- timeout_irq_o:
  - Cleared only by reset, or by a debug-slave write (target = debug, wbs_we_i=1) acknowledged with wbs_sel_i[3]=1.
  - A new timeout in the same cycle as a clear leaves the flag set.
- Reset mid-transaction: return to IDLE immediately with no ack; the slave sees its strobe drop.

Optional Feature:
- Macro: WB_ROUTER_TIMEOUT_EN.
- Defined: watchdog and the timeout_* outputs behave as specified above.
- Undefined:
  - No watchdog; BUSY waits for an ack or a master abort indefinitely.
  - timeout_irq_o, timeout_cnt_o and timeout_adr_o are tied to 0; the counter logic is removed.

Test Plan:
- Read 0x300FFFF8, debug acks 2 cycles after its stb with 0x12345678: debug_stb_o high from N+1; wbs_ack_o one cycle, 1 cycle after debug_ack_i; wbs_dat_o=0x12345678; user_stb_o stays 0.
- Write 0x30000010, user acks 1 cycle after its stb: user_stb_o high from N+1; wbs_ack_o single pulse; debug_cyc_o stays 0; timeout_cnt_o=0.
- Read 0x30000000 with the user slave never acking, TIMEOUT_CYCLES=4: ack 4 BUSY cycles after entry; wbs_dat_o=0xDEADBEEF; timeout_irq_o=1; timeout_cnt_o=1; timeout_adr_o=0x30000000.
- With TIMEOUT_CYCLES=4, user ack lands in the same cycle the watchdog expires: data is the slave's; timeout_cnt_o unchanged; irq unchanged.
- Master drops wbs_cyc_i in BUSY: slave strobes fall the next cycle; no wbs_ack_o; FSM IDLE; next request serviced normally.
- Assert wb_rst_i during BUSY after 2 timeouts: all outputs 0 next cycle, including timeout_cnt_o=0; no ack is ever issued for the aborted transaction.

Source files
------------

// File: rtl/wb_slave_router_if.sv
// Management-side Wishbone bus between the master and wb_slave_router.
// The master modport drives requests; the slave modport returns ack/data.
interface wb_slave_router_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i,
      output wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
      input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/wb_slave_router.sv
// Registered Wishbone router: management port to user or debug slave.
// WB_ROUTER_TIMEOUT_EN enables the watchdog and the timeout_* outputs.
module wb_slave_router #(
   parameter logic [28:0] DEBUG_BASE     = 29'h601FFFF,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter int          CNT_W          = 8,
   parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   wb_slave_router_if.slave wbs,
   output logic             user_cyc_o,
   output logic             user_stb_o,
   input  logic             user_ack_i,
   input  logic [31:0]      user_dat_i,
   output logic             debug_cyc_o,
   output logic             debug_stb_o,
   input  logic             debug_ack_i,
   input  logic [31:0]      debug_dat_i,
   output logic             timeout_irq_o,
   output logic [CNT_W-1:0] timeout_cnt_o,
   output logic [31:0]      timeout_adr_o
);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam logic [CNT_W-1:0] WD_LAST =
      CNT_W'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic        tgt_dbg;
   logic        hit_dbg;
   logic        ack_sel;
   logic        live;
   logic        tmo;
   logic [31:0] dat_sel;
   logic        unused_ok;

   assign hit_dbg = wbs.wbs_adr_i[31:3] == DEBUG_BASE;
   assign ack_sel = tgt_dbg ? debug_ack_i : user_ack_i;
   assign dat_sel = tgt_dbg ? debug_dat_i : user_dat_i;
   assign live    = (state == BUSY) && wbs.wbs_cyc_i;

   assign unused_ok = ^{wbs.wbs_we_i, wbs.wbs_sel_i,
                        wbs.wbs_adr_i[2:0], wbs.wbs_dat_i,
                        WD_LAST};

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state         <= IDLE;
         tgt_dbg       <= 1'b0;
         user_cyc_o    <= 1'b0;
         user_stb_o    <= 1'b0;
         debug_cyc_o   <= 1'b0;
         debug_stb_o   <= 1'b0;
         wbs.wbs_ack_o <= 1'b0;
         wbs.wbs_dat_o <= '0;
      end else begin
         wbs.wbs_ack_o <= 1'b0;
         case (state)
            IDLE: begin
               if (wbs.wbs_cyc_i && wbs.wbs_stb_i) begin
                  tgt_dbg     <= hit_dbg;
                  user_cyc_o  <= !hit_dbg;
                  user_stb_o  <= !hit_dbg;
                  debug_cyc_o <= hit_dbg;
                  debug_stb_o <= hit_dbg;
                  state       <= BUSY;
               end
            end
            BUSY: begin
               // Master abort wins over anything the slave does.
               if (!wbs.wbs_cyc_i) begin
                  user_cyc_o  <= 1'b0;
                  user_stb_o  <= 1'b0;
                  debug_cyc_o <= 1'b0;
                  debug_stb_o <= 1'b0;
                  state       <= IDLE;
               end else if (ack_sel || tmo) begin
                  wbs.wbs_dat_o <= ack_sel ? dat_sel : TIMEOUT_DATA;
                  wbs.wbs_ack_o <= 1'b1;
                  user_cyc_o    <= 1'b0;
                  user_stb_o    <= 1'b0;
                  debug_cyc_o   <= 1'b0;
                  debug_stb_o   <= 1'b0;
                  state         <= RESP;
               end
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef WB_ROUTER_TIMEOUT_EN
   logic [CNT_W-1:0] wd;
   logic             rec_tmo;
   logic             irq_clr;

   assign tmo     = (state == BUSY) && (wd == WD_LAST);
   assign rec_tmo = live && !ack_sel && tmo;
   assign irq_clr = live && ack_sel && tgt_dbg &&
                    wbs.wbs_we_i && wbs.wbs_sel_i[3];

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wd            <= '0;
         timeout_irq_o <= 1'b0;
         timeout_cnt_o <= '0;
         timeout_adr_o <= '0;
      end else begin
         if (state == IDLE)
            wd <= '0;
         else if (state == BUSY)
            wd <= wd + CNT_W'(1);
         // A fresh timeout keeps the flag set over a clear.
         if (rec_tmo) begin
            timeout_irq_o <= 1'b1;
            timeout_adr_o <= wbs.wbs_adr_i;
            if (timeout_cnt_o != '1)
               timeout_cnt_o <= timeout_cnt_o + CNT_W'(1);
         end else if (irq_clr) begin
            timeout_irq_o <= 1'b0;
         end
      end
   end
`else
   assign tmo           = 1'b0;
   assign timeout_irq_o = 1'b0;
   assign timeout_cnt_o = '0;
   assign timeout_adr_o = '0;
`endif
endmodule

// File: tb/tb_wb_slave_router.sv
// Scoreboard bench for wb_slave_router with TIMEOUT_CYCLES=4.
// Timeout scenarios run only when WB_ROUTER_TIMEOUT_EN is defined.
module tb_wb_slave_router;
   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        user_cyc, user_stb, debug_cyc, debug_stb;
   logic        user_ack = 1'b0, debug_ack = 1'b0;
   logic [31:0] user_dat = '0, debug_dat = '0;
   logic        irq;
   logic [7:0]  tcnt;
   logic [31:0] tadr;

   wb_slave_router_if bus();

   wb_slave_router #(.TIMEOUT_CYCLES(T)) dut (
      .wb_clk_i      (clk),
      .wb_rst_i      (rst),
      .wbs           (bus),
      .user_cyc_o    (user_cyc),
      .user_stb_o    (user_stb),
      .user_ack_i    (user_ack),
      .user_dat_i    (user_dat),
      .debug_cyc_o   (debug_cyc),
      .debug_stb_o   (debug_stb),
      .debug_ack_i   (debug_ack),
      .debug_dat_i   (debug_dat),
      .timeout_irq_o (irq),
      .timeout_cnt_o (tcnt),
      .timeout_adr_o (tadr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] dat;
      logic        irq;
      logic [7:0]  cnt;
      logic [31:0] adr;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] strobes();
      return {user_cyc, user_stb, debug_cyc, debug_stb};
   endfunction

   // Monitor: every ack presented to the master consumes one expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.wbs_ack_o) begin
            if (q.size() == 0) begin
               chk("spurious_ack", 1, 0);
            end else begin
               e = q.pop_front();
               chk("resp_dat", bus.wbs_dat_o, e.dat);
               chk("resp_irq", {31'd0, irq}, {31'd0, e.irq});
               chk("resp_cnt", {24'd0, tcnt}, {24'd0, e.cnt});
               chk("resp_adr", tadr, e.adr);
            end
         end
      end
   end

   task automatic xact(
      input logic [31:0] adr, input logic we, input logic [3:0] sel,
      input logic dbg, input int d, input int wrong_at,
      input logic [31:0] sdat, input int exp_lat,
      input logic [31:0] e_dat, input logic e_irq,
      input logic [7:0] e_cnt, input logic [31:0] e_adr);
      int   lat;
      logic got;
      exp_t e;
      e.dat = e_dat;
      e.irq = e_irq;
      e.cnt = e_cnt;
      e.adr = e_adr;
      q.push_back(e);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_adr_i = adr;
      bus.wbs_we_i  = we;
      bus.wbs_sel_i = sel;
      bus.wbs_dat_i = ~adr;
      tick;
      chk("busy_strobes", {28'd0, strobes()},
          {28'd0, dbg ? 4'b0011 : 4'b1100});
      lat = 0;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         if (dbg) begin
            debug_ack = (k == d);
            debug_dat = sdat;
            user_ack  = (k == wrong_at);
            user_dat  = 32'hBAD0BAD0;
         end else begin
            user_ack  = (k == d);
            user_dat  = sdat;
            debug_ack = (k == wrong_at);
            debug_dat = 32'hBAD0BAD0;
         end
         tick;
         lat++;
         if (bus.wbs_ack_o) got = 1'b1;
      end
      user_ack  = 1'b0;
      debug_ack = 1'b0;
      chk("ack_seen", {31'd0, got}, 32'd1);
      chk("ack_latency", lat, exp_lat);
      chk("resp_strobes", {28'd0, strobes()}, 32'd0);
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      tick;
      chk("ack_pulse", {31'd0, bus.wbs_ack_o}, 32'd0);
   endtask

   task automatic abort_user(input logic [31:0] adr);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_adr_i = adr;
      bus.wbs_we_i  = 1'b0;
      tick;
      chk("abort_busy_strobes", {28'd0, strobes()}, 32'hC);
      tick;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      tick;
      chk("abort_strobes", {28'd0, strobes()}, 32'd0);
      repeat (3) begin
         tick;
         chk("abort_no_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ack"}, {31'd0, bus.wbs_ack_o}, 32'd0);
      chk({tag, "_dat"}, bus.wbs_dat_o, 32'd0);
      chk({tag, "_strobes"}, {28'd0, strobes()}, 32'd0);
      chk({tag, "_irq"}, {31'd0, irq}, 32'd0);
      chk({tag, "_cnt"}, {24'd0, tcnt}, 32'd0);
      chk({tag, "_adr"}, tadr, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_sel_i = 4'h0;
      bus.wbs_adr_i = '0;
      bus.wbs_dat_i = '0;
      rst = 1'b1;
      tick;
      tick;
      check_zero("reset");
      rst = 1'b0;
      tick;

      xact(32'h300FFFF8, 1'b0, 4'hF, 1'b1, 2, -1, 32'h12345678, 3,
           32'h12345678, 1'b0, 8'd0, 32'h0);
      xact(32'h30000010, 1'b1, 4'hF, 1'b0, 1, -1, 32'hCAFE0001, 2,
           32'hCAFE0001, 1'b0, 8'd0, 32'h0);
`ifdef WB_ROUTER_TIMEOUT_EN
      xact(32'h30000000, 1'b0, 4'hF, 1'b0, -1, -1, 32'h0, 4,
           32'hDEADBEEF, 1'b1, 8'd1, 32'h30000000);
      xact(32'h30000004, 1'b0, 4'hF, 1'b0, 3, -1, 32'h0BADF00D, 4,
           32'h0BADF00D, 1'b1, 8'd1, 32'h30000000);
      xact(32'h300FFFFC, 1'b1, 4'h7, 1'b1, 0, -1, 32'h11110000, 1,
           32'h11110000, 1'b1, 8'd1, 32'h30000000);
      xact(32'h300FFFF8, 1'b1, 4'h8, 1'b1, 1, -1, 32'h22220000, 2,
           32'h22220000, 1'b0, 8'd1, 32'h30000000);
      abort_user(32'h30000020);
      xact(32'h30000008, 1'b0, 4'hF, 1'b0, 0, -1, 32'h55AA55AA, 1,
           32'h55AA55AA, 1'b0, 8'd1, 32'h30000000);
      xact(32'h30000040, 1'b0, 4'hF, 1'b0, -1, 1, 32'h0, 4,
           32'hDEADBEEF, 1'b1, 8'd2, 32'h30000040);
`else
      abort_user(32'h30000020);
      xact(32'h30000008, 1'b0, 4'hF, 1'b0, 0, 1, 32'h55AA55AA, 1,
           32'h55AA55AA, 1'b0, 8'd0, 32'h0);
      xact(32'h300FFFF8, 1'b0, 4'hF, 1'b1, 5, 0, 32'h0F0F0F0F, 6,
           32'h0F0F0F0F, 1'b0, 8'd0, 32'h0);
`endif
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_adr_i = 32'h30000080;
      bus.wbs_we_i  = 1'b0;
      tick;
      tick;
      rst = 1'b1;
      tick;
      check_zero("midreset");
      rst = 1'b0;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      repeat (3) begin
         tick;
         chk("midreset_no_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
      end
      xact(32'h30000000, 1'b0, 4'hF, 1'b0, 0, -1, 32'h77777777, 1,
           32'h77777777, 1'b0, 8'd0, 32'h0);

      repeat (2) tick;
      chk("queue_drained", q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
